// File: rtl/cfgreg_boot_seq.sv
// ---------------------------------------------------------------------------
// cfgreg_boot_seq
//   APB master that boots a core through the cfgreg slave. On an accepted
//   start it writes RSTN=0, waits RST_HOLD cycles, writes BOOTVEC and
//   DDROFFSET, then writes RSTN=1. A slave error or an ACCESS phase that
//   outlasts TIMEOUT cycles aborts the sequence with a sticky err/err_code.
//
//   Optional feature macro: CFGREG_BOOT_VERIFY_EN
//     When defined, a readback of the same address follows the BOOTVEC and
//     the final RSTN writes. A readback mismatch aborts with err_code=3.
//
//   Register offsets mirror cfgreg_mmap.h:
//     RSTN = 0x000, BOOTVEC = 0x004, DDROFFSET = 0x008
// ---------------------------------------------------------------------------
module cfgreg_boot_seq #(
  parameter int unsigned RST_HOLD = 4,   // legal 1..255
  parameter int unsigned TIMEOUT  = 16   // legal 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] boot_vec,
  input  logic [31:0] ddr_off,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [11:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [11:0] ADDR_RSTN      = 12'h000;
  localparam logic [11:0] ADDR_BOOTVEC   = 12'h004;
  localparam logic [11:0] ADDR_DDROFFSET = 12'h008;

`ifdef CFGREG_BOOT_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_ACCESS, ST_HOLD, ST_DONE, ST_ERR
  } state_t;

  // R1/R3 are the readbacks that only exist when verification is enabled.
  typedef enum logic [2:0] {
    STEP_W0, STEP_W1, STEP_R1, STEP_W2, STEP_W3, STEP_R3
  } step_t;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_SLVERR, ERR_TIMEOUT, ERR_VERIFY
  } err_t;

  state_t      state_q, state_d;
  step_t       step_q, step_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [31:0] bv_q, bv_d;
  logic [31:0] dof_q, dof_d;
  logic        busy_d, done_d, err_d;
  logic [1:0]  code_d;
  logic        psel_d, penable_d, pwrite_d;
  logic [11:0] paddr_d;
  logic [31:0] pwdata_d;
  logic        rd_mismatch;

  assign rd_mismatch = ((step_q == STEP_R1) && (prdata != bv_q)) ||
                       ((step_q == STEP_R3) && !prdata[0]);

  // Next-state, step sequencing, counters and status flags.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    step_d  = step_q;
    tcnt_d  = tcnt_q;
    hcnt_d  = hcnt_q;
    bv_d    = bv_q;
    dof_d   = dof_q;
    busy_d  = busy;
    done_d  = done;
    err_d   = err;
    code_d  = err_code;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          bv_d    = boot_vec;
          dof_d   = ddr_off;
          done_d  = 1'b0;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
          busy_d  = 1'b1;
          step_d  = STEP_W0;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
        tcnt_d  = '0;
      end

      ST_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            code_d  = ERR_SLVERR;
          end else if (rd_mismatch) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            code_d  = ERR_VERIFY;
          end else begin
            case (step_q)
              STEP_W0: begin
                state_d = ST_HOLD;
                hcnt_d  = '0;
              end
              STEP_W1: begin
                state_d = ST_SETUP;
                if (VERIFY) step_d = STEP_R1;
                else        step_d = STEP_W2;
              end
              STEP_R1: begin
                state_d = ST_SETUP;
                step_d  = STEP_W2;
              end
              STEP_W2: begin
                state_d = ST_SETUP;
                step_d  = STEP_W3;
              end
              STEP_W3: begin
                if (VERIFY) begin
                  state_d = ST_SETUP;
                  step_d  = STEP_R3;
                end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                end
              end
              STEP_R3: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
              end
              default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            endcase
          end
        end else if (tcnt_q == TO_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          code_d  = ERR_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      ST_HOLD: begin
        if (hcnt_q == HOLD_LAST) begin
          state_d = ST_SETUP;
          step_d  = STEP_W1;
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // APB drive values for the coming cycle, derived from the next state so
  // that the bus outputs can be registered without adding latency.
  always_comb begin
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = '0;
    pwdata_d  = '0;
    if ((state_d == ST_SETUP) || (state_d == ST_ACCESS)) begin
      psel_d    = 1'b1;
      penable_d = (state_d == ST_ACCESS);
      case (step_d)
        STEP_W0: begin
          paddr_d  = ADDR_RSTN;
          pwrite_d = 1'b1;
          pwdata_d = 32'd0;
        end
        STEP_W1: begin
          paddr_d  = ADDR_BOOTVEC;
          pwrite_d = 1'b1;
          pwdata_d = bv_d;
        end
        STEP_R1: paddr_d = ADDR_BOOTVEC;
        STEP_W2: begin
          paddr_d  = ADDR_DDROFFSET;
          pwrite_d = 1'b1;
          pwdata_d = dof_d;
        end
        STEP_W3: begin
          paddr_d  = ADDR_RSTN;
          pwrite_d = 1'b1;
          pwdata_d = 32'd1;
        end
        STEP_R3: paddr_d = ADDR_RSTN;
        default: ;
      endcase
    end
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      step_q   <= STEP_W0;
      tcnt_q   <= '0;
      hcnt_q   <= '0;
      bv_q     <= '0;
      dof_q    <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      tcnt_q   <= tcnt_d;
      hcnt_q   <= hcnt_d;
      bv_q     <= bv_d;
      dof_q    <= dof_d;
      psel     <= psel_d;
      penable  <= penable_d;
      pwrite   <= pwrite_d;
      paddr    <= paddr_d;
      pwdata   <= pwdata_d;
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      err_code <= code_d;
    end
  end

endmodule

// File: tb/tb_cfgreg_boot_seq.sv
// ---------------------------------------------------------------------------
// tb_cfgreg_boot_seq
//   Drives cfgreg_boot_seq against a behavioural cfgreg APB slave with
//   random wait states, and checks transfer order, contents and completion
//   timing against expectations computed from phase lengths.
//   Honours CFGREG_BOOT_VERIFY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_cfgreg_boot_seq;

  localparam int RH   = 4;
  localparam int TO   = 16;
  localparam int XFER = 2;   // cycles per zero-wait APB transfer

  localparam logic [11:0] A_RSTN    = 12'h000;
  localparam logic [11:0] A_BOOTVEC = 12'h004;
  localparam logic [11:0] A_DDROFF  = 12'h008;

`ifdef CFGREG_BOOT_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int N_READS = VERIFY ? 2 : 0;

  typedef struct packed {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] data;
    logic        slverr;
  } xfer_t;
  typedef xfer_t xq_t[$];

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] boot_vec, ddr_off;
  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        busy, done, err;
  logic [1:0]  err_code;

  int n_total = 0;
  int n_pass  = 0;

  // Slave model state and fault knobs.
  logic        m_rstn;
  logic [31:0] m_bootvec, m_ddroff;
  bit          rand_waits, stall_en, err_en, ovr_en;
  logic [11:0] stall_addr, err_addr;
  logic [31:0] ovr_val;
  int          waits_left, waits_sum, stall_cycles;
  xfer_t       log_q[$];

  cfgreg_boot_seq #(.RST_HOLD(RH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .boot_vec(boot_vec), .ddr_off(ddr_off),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  function automatic logic [31:0] model_read(logic [11:0] a);
    if (a == A_RSTN)    return {31'd0, m_rstn};
    if (a == A_BOOTVEC) return m_bootvec;
    return 32'd0;  // DDROFFSET is write-only
  endfunction

  // Behavioural cfgreg slave: responds on the negative edge, logs every
  // completed transfer.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end else if (psel === 1'b1 && penable !== 1'b1) begin
      pready  = 1'b0;
      pslverr = 1'b0;
      if (stall_en && paddr == stall_addr) waits_left = 1_000_000;
      else waits_left = rand_waits ? int'($urandom_range(0, 3)) : 0;
    end else if (psel === 1'b1 && penable === 1'b1) begin
      if (waits_left > 0) begin
        pready  = 1'b0;
        pslverr = 1'b0;
        waits_left--;
        waits_sum++;
        stall_cycles++;
      end else begin
        xfer_t x;
        pready  = 1'b1;
        pslverr = err_en && (paddr == err_addr);
        if (pwrite) prdata = $urandom;
        else if (ovr_en && paddr == A_BOOTVEC) prdata = ovr_val;
        else prdata = model_read(paddr);
        x.addr   = paddr;
        x.wr     = pwrite;
        x.data   = pwrite ? pwdata : prdata;
        x.slverr = pslverr;
        log_q.push_back(x);
        if (pwrite && !pslverr) begin
          if (paddr == A_RSTN)    m_rstn    = pwdata[0];
          if (paddr == A_BOOTVEC) m_bootvec = pwdata;
          if (paddr == A_DDROFF)  m_ddroff  = pwdata;
        end
      end
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  function automatic xfer_t mk(logic [11:0] a, logic w, logic [31:0] d, logic e);
    xfer_t x;
    x.addr = a; x.wr = w; x.data = d; x.slverr = e;
    return x;
  endfunction

  // Expected full transfer list for a successful boot.
  function automatic xq_t full_seq(logic [31:0] bv, logic [31:0] dof);
    xq_t q;
    q.push_back(mk(A_RSTN, 1'b1, 32'd0, 1'b0));
    q.push_back(mk(A_BOOTVEC, 1'b1, bv, 1'b0));
    if (VERIFY) q.push_back(mk(A_BOOTVEC, 1'b0, bv, 1'b0));
    q.push_back(mk(A_DDROFF, 1'b1, dof, 1'b0));
    q.push_back(mk(A_RSTN, 1'b1, 32'd1, 1'b0));
    if (VERIFY) q.push_back(mk(A_RSTN, 1'b0, 32'd1, 1'b0));
    return q;
  endfunction

  // Index of first divergence between logged and expected lists, -1 if equal.
  function automatic int first_diff(xq_t exp);
    int n = (log_q.size() < exp.size()) ? log_q.size() : exp.size();
    for (int i = 0; i < n; i++) if (log_q[i] !== exp[i]) return i;
    if (log_q.size() != exp.size()) return n;
    return -1;
  endfunction

  task automatic show_xfer_fail(string name, xq_t exp);
    int    k = first_diff(exp);
    xfer_t g = (k < log_q.size()) ? log_q[k] : '0;
    xfer_t e = (k < exp.size()) ? exp[k] : '0;
    $display("FAIL %s: transfer #%0d of %0d got addr=%h wr=%b data=%h slverr=%b, want (of %0d) addr=%h wr=%b data=%h slverr=%b",
             name, k, log_q.size(), g.addr, g.wr, g.data, g.slverr,
             exp.size(), e.addr, e.wr, e.data, e.slverr);
  endtask

  task automatic clear_knobs();
    rand_waits = 1'b0; stall_en = 1'b0; err_en = 1'b0; ovr_en = 1'b0;
    stall_addr = '0; err_addr = '0; ovr_val = '0;
  endtask

  // Presents start for one cycle; returns at the first negedge after the
  // accept edge (sample index 1). Inputs are scrambled afterwards so that
  // only the captured values can appear on the bus.
  task automatic do_start(input logic [31:0] bv, input logic [31:0] dof);
    @(negedge clk);
    log_q.delete();
    waits_sum    = 0;
    stall_cycles = 0;
    boot_vec = bv;
    ddr_off  = dof;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    boot_vec = $urandom;
    ddr_off  = $urandom;
  endtask

  // Advances until busy drops; j = sample index where busy was first 0,
  // or -1 if the budget ran out.
  task automatic wait_idle(input int j0, output int j);
    j = j0;
    while (busy === 1'b1 && j < 400) begin
      @(negedge clk);
      j++;
    end
    if (j >= 400) j = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({psel, penable, pwrite, paddr, pwdata, busy, done, err, err_code} !== '0)
      $display("FAIL reset_outputs: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h busy=%b done=%b err=%b code=%0d, want all 0",
               psel, penable, pwrite, paddr, pwdata, busy, done, err, err_code);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({psel, busy, done, err} !== 4'b0)
      $display("FAIL idle_after_reset: got psel=%b busy=%b done=%b err=%b, want 0000", psel, busy, done, err);
    else n_pass++;
  endtask

  task automatic test_nominal();
    int   j, exp_j;
    xq_t  exp;
    clear_knobs();
    do_start(32'h8000_0000, 32'h2000_0000);
    wait_idle(1, j);
    exp_j = 1 + (4 + N_READS) * XFER + RH;
    exp   = full_seq(32'h8000_0000, 32'h2000_0000);
    n_total++;
    if (j !== exp_j) $display("FAIL nominal_done_edge: got %0d want %0d", j, exp_j);
    else n_pass++;
    n_total++;
    if ({done, err, err_code} !== 4'b1000)
      $display("FAIL nominal_status: got done=%b err=%b code=%0d, want 1 0 0", done, err, err_code);
    else n_pass++;
    n_total++;
    if ({psel, penable} !== 2'b00) $display("FAIL nominal_bus_idle: got psel=%b penable=%b want 0 0", psel, penable);
    else n_pass++;
    n_total++;
    if (first_diff(exp) != -1) show_xfer_fail("nominal_xfers", exp);
    else n_pass++;
    n_total++;
    if ({m_rstn, m_bootvec, m_ddroff} !== {1'b1, 32'h8000_0000, 32'h2000_0000})
      $display("FAIL nominal_regs: got rstn=%b bootvec=%h ddroff=%h want 1 80000000 20000000", m_rstn, m_bootvec, m_ddroff);
    else n_pass++;
  endtask

  task automatic test_random_waits();
    for (int it = 0; it < 6; it++) begin
      int          j, exp_j;
      logic [31:0] bv, dof;
      xq_t         exp;
      clear_knobs();
      rand_waits = 1'b1;
      bv  = $urandom;
      dof = $urandom;
      do_start(bv, dof);
      wait_idle(1, j);
      exp_j = 1 + (4 + N_READS) * XFER + RH + waits_sum;
      exp   = full_seq(bv, dof);
      n_total++;
      if (j !== exp_j) $display("FAIL rand%0d_done_edge: got %0d want %0d", it, j, exp_j);
      else n_pass++;
      n_total++;
      if ({done, err, err_code} !== 4'b1000)
        $display("FAIL rand%0d_status: got done=%b err=%b code=%0d, want 1 0 0", it, done, err, err_code);
      else n_pass++;
      n_total++;
      if (first_diff(exp) != -1) show_xfer_fail($sformatf("rand%0d_xfers", it), exp);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int  j, exp_j;
    xq_t exp;
    clear_knobs();
    stall_en   = 1'b1;
    stall_addr = A_BOOTVEC;
    do_start($urandom, $urandom);
    wait_idle(1, j);
    // W0 transfer and the hold, then W1 SETUP; TO stalled ACCESS cycles.
    exp_j = 1 + XFER + RH + 1 + TO;
    exp.push_back(mk(A_RSTN, 1'b1, 32'd0, 1'b0));
    n_total++;
    if (j !== exp_j) $display("FAIL timeout_edge: got %0d want %0d", j, exp_j);
    else n_pass++;
    n_total++;
    if ({done, err, err_code, psel, penable} !== 6'b011000)
      $display("FAIL timeout_status: got done=%b err=%b code=%0d psel=%b pen=%b, want 0 1 2 0 0",
               done, err, err_code, psel, penable);
    else n_pass++;
    n_total++;
    if (stall_cycles !== TO) $display("FAIL timeout_cycles: got %0d stalled ACCESS cycles want %0d", stall_cycles, TO);
    else n_pass++;
    n_total++;
    if (first_diff(exp) != -1) show_xfer_fail("timeout_xfers", exp);
    else n_pass++;
  endtask

  task automatic test_pslverr();
    int          j, exp_j;
    logic [31:0] bv, dof;
    xq_t         exp;
    clear_knobs();
    err_en   = 1'b1;
    err_addr = A_DDROFF;
    bv  = $urandom;
    dof = $urandom;
    do_start(bv, dof);
    wait_idle(1, j);
    exp_j = 1 + (3 + (VERIFY ? 1 : 0)) * XFER + RH;
    exp.push_back(mk(A_RSTN, 1'b1, 32'd0, 1'b0));
    exp.push_back(mk(A_BOOTVEC, 1'b1, bv, 1'b0));
    if (VERIFY) exp.push_back(mk(A_BOOTVEC, 1'b0, bv, 1'b0));
    exp.push_back(mk(A_DDROFF, 1'b1, dof, 1'b1));
    n_total++;
    if (j !== exp_j) $display("FAIL slverr_edge: got %0d want %0d", j, exp_j);
    else n_pass++;
    n_total++;
    if ({done, err, err_code} !== 4'b0101)
      $display("FAIL slverr_status: got done=%b err=%b code=%0d, want 0 1 1", done, err, err_code);
    else n_pass++;
    n_total++;
    if (first_diff(exp) != -1) show_xfer_fail("slverr_xfers", exp);
    else n_pass++;
    n_total++;
    if (m_rstn !== 1'b0) $display("FAIL slverr_core_held: got rstn=%b want 0", m_rstn);
    else n_pass++;
  endtask

  task automatic test_start_mid_hold();
    int          j, exp_j;
    logic [31:0] bv, dof;
    xq_t         exp;
    clear_knobs();
    bv  = $urandom;
    dof = $urandom;
    do_start(bv, dof);
    @(negedge clk);              // sample 2 (W0 ACCESS)
    @(negedge clk);              // sample 3 (HOLD)
    start    = 1'b1;
    boot_vec = ~bv;
    ddr_off  = ~dof;
    @(negedge clk);              // start sampled while holding
    start = 1'b0;
    wait_idle(4, j);
    exp_j = 1 + (4 + N_READS) * XFER + RH;
    exp   = full_seq(bv, dof);
    n_total++;
    if (j !== exp_j) $display("FAIL hold_start_edge: got %0d want %0d", j, exp_j);
    else n_pass++;
    n_total++;
    if (first_diff(exp) != -1) show_xfer_fail("hold_start_xfers", exp);
    else n_pass++;
  endtask

  task automatic test_rerun_after_done();
    int          j, exp_j;
    logic [31:0] bv, dof;
    xq_t         exp;
    clear_knobs();
    bv  = $urandom;
    dof = $urandom;
    n_total++;
    if (done !== 1'b1) $display("FAIL rerun_precond_done: got %b want 1", done);
    else n_pass++;
    do_start(bv, dof);
    n_total++;
    if ({done, busy} !== 2'b01) $display("FAIL rerun_clear: got done=%b busy=%b want 0 1", done, busy);
    else n_pass++;
    wait_idle(1, j);
    exp_j = 1 + (4 + N_READS) * XFER + RH;
    exp   = full_seq(bv, dof);
    n_total++;
    if (j !== exp_j || done !== 1'b1)
      $display("FAIL rerun_done: got edge %0d done=%b want edge %0d done=1", j, done, exp_j);
    else n_pass++;
    n_total++;
    if (first_diff(exp) != -1) show_xfer_fail("rerun_xfers", exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    int          j, k, exp_j;
    logic [31:0] bv, dof;
    xq_t         exp;
    clear_knobs();
    stall_en   = 1'b1;
    stall_addr = A_BOOTVEC;
    do_start($urandom, $urandom);
    k = 0;
    while (!(psel === 1'b1 && penable === 1'b1 && paddr === A_BOOTVEC) && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (k >= 60) $display("FAIL rstmid_reach_w1: got no W1 ACCESS in %0d cycles, want one", k);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({psel, penable, pwrite, paddr, pwdata, busy, done, err, err_code} !== '0)
      $display("FAIL rstmid_outputs: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h busy=%b done=%b err=%b code=%0d, want all 0",
               psel, penable, pwrite, paddr, pwdata, busy, done, err, err_code);
    else n_pass++;
    rst = 1'b0;
    clear_knobs();
    bv  = $urandom;
    dof = $urandom;
    do_start(bv, dof);
    wait_idle(1, j);
    exp_j = 1 + (4 + N_READS) * XFER + RH;
    exp   = full_seq(bv, dof);
    n_total++;
    if (j !== exp_j || done !== 1'b1)
      $display("FAIL rstmid_rerun_done: got edge %0d done=%b want edge %0d done=1", j, done, exp_j);
    else n_pass++;
    n_total++;
    if (first_diff(exp) != -1) show_xfer_fail("rstmid_rerun_xfers", exp);
    else n_pass++;
  endtask

`ifdef CFGREG_BOOT_VERIFY_EN
  task automatic test_verify_mismatch();
    int          j, exp_j;
    logic [31:0] dof;
    xq_t         exp;
    clear_knobs();
    ovr_en  = 1'b1;
    ovr_val = 32'h1234_5678;
    dof     = $urandom;
    do_start(32'h8000_0000, dof);
    wait_idle(1, j);
    exp_j = 1 + 3 * XFER + RH;
    exp.push_back(mk(A_RSTN, 1'b1, 32'd0, 1'b0));
    exp.push_back(mk(A_BOOTVEC, 1'b1, 32'h8000_0000, 1'b0));
    exp.push_back(mk(A_BOOTVEC, 1'b0, 32'h1234_5678, 1'b0));
    n_total++;
    if (j !== exp_j) $display("FAIL verify_edge: got %0d want %0d", j, exp_j);
    else n_pass++;
    n_total++;
    if ({done, err, err_code} !== 4'b0111)
      $display("FAIL verify_status: got done=%b err=%b code=%0d, want 0 1 3", done, err, err_code);
    else n_pass++;
    n_total++;
    if (first_diff(exp) != -1) show_xfer_fail("verify_xfers", exp);
    else n_pass++;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    boot_vec = '0;
    ddr_off  = '0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    prdata   = '0;
    m_rstn    = 1'b0;
    m_bootvec = '0;
    m_ddroff  = '0;
    waits_left = 0;
    clear_knobs();

    test_reset();
    test_nominal();
    test_random_waits();
    test_timeout();
    test_pslverr();
    test_start_mid_hold();
    test_rerun_after_done();
    test_reset_mid_access();
`ifdef CFGREG_BOOT_VERIFY_EN
    test_verify_mismatch();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
